// File: rtl/rotate_key_conditioner.sv
// rotate_key_conditioner: syncs and debounces two active-low rotation keys, emits rotate pulses with hold-to-repeat.
// Latency: first pulse DEBOUNCE_CYCLES+2 edges after a key is first sampled low; repeats after REPEAT_DELAY, then every REPEAT_PERIOD.
// Backpressure: none; rotate_* are fire-and-forget single-cycle commands to input_control.
// Ports: clock/resetn; key_left_n/key_right_n raw async keys (0 = pressed);
//        rotate_left/rotate_right registered one-cycle pulses; pressed_left/pressed_right debounced levels (1 = held).
module rotate_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_left_n,
    input  logic key_right_n,
    output logic rotate_left,
    output logic rotate_right,
    output logic pressed_left,
    output logic pressed_right
);
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    // Index 0 = left, index 1 = right throughout.
    logic [1:0] key_n;
    logic [1:0] pressed;

    assign key_n = {key_right_n, key_left_n};

    for (genvar g = 0; g < 2; g++) begin : g_key
        logic             sync_q1;
        logic             sync_q2;
        logic             held;
        logic             level;
        logic [CNT_W-1:0] cnt;

        assign held = ~sync_q2;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                sync_q1 <= 1'b1;
                sync_q2 <= 1'b1;
                cnt     <= '0;
                level   <= 1'b0;
            end else begin
                sync_q1 <= key_n[g];
                sync_q2 <= sync_q1;
                // Any agreement restarts the run, so only an unbroken
                // DEBOUNCE_CYCLES-long disagreement flips the level.
                if (held == level) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign pressed[g] = level;
    end

    assign pressed_left  = pressed[0];
    assign pressed_right = pressed[1];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;      // 0 = left, 1 = right
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             rot_l_d, rot_r_d;
    logic             fire;
    logic             dir_held;
    logic             opp_held;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        tmr_d    = tmr_q;
        fire     = 1'b0;
        dir_held = pressed[dir_q];
        opp_held = pressed[~dir_q];

        case (state_q)
            ST_IDLE: begin
                // Both keys held is ambiguous: wait until exactly one remains.
                if (pressed[0] ^ pressed[1]) begin
                    dir_d   = pressed[1];
                    fire    = 1'b1;
                    tmr_d   = '0;
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                // Abort wins over a coincident expiry so no pulse escapes on release/takeover.
                if (!dir_held || opp_held) begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else if (tmr_q == DELAY_LAST) begin
                    fire    = 1'b1;
                    tmr_d   = '0;
                    state_d = ST_REPEAT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_REPEAT: begin
                if (!dir_held || opp_held) begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else if (tmr_q == PERIOD_LAST) begin
                    fire  = 1'b1;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                tmr_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        rot_l_d = fire & ~dir_d;
        rot_r_d = fire & dir_d;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            tmr_q        <= '0;
            rotate_left  <= 1'b0;
            rotate_right <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            tmr_q        <= tmr_d;
            rotate_left  <= rot_l_d;
            rotate_right <= rot_r_d;
        end
    end

endmodule

// File: tb/tb_rotate_key_conditioner.sv
// tb_rotate_key_conditioner: scoreboard bench for rotate_key_conditioner with short debounce/repeat timing.
// Latency: expected pulse cycles are derived from key stimulus and popped as the DUT pulses.
// Backpressure: n/a.
module tb_rotate_key_conditioner;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clock       = 1'b0;
    logic resetn      = 1'b0;
    logic key_left_n  = 1'b1;
    logic key_right_n = 1'b1;
    logic rotate_left;
    logic rotate_right;
    logic pressed_left;
    logic pressed_right;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int n;
    int m;
    bit seen;

    typedef struct {
        int t;
        bit dir;   // 0 = left, 1 = right
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t mon_p;

    rotate_key_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .key_left_n   (key_left_n),
        .key_right_n  (key_right_n),
        .rotate_left  (rotate_left),
        .rotate_right (rotate_right),
        .pressed_left (pressed_left),
        .pressed_right(pressed_right)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // A hold of one key from first pulse t0 until the cycle f at which it stops
    // being the sole pressed key: pulses at t0, t0+RD, then every RP, none after f.
    task automatic push_hold(input bit dir, input int t0, input int f);
        pulse_t p;
        int     t = t0;
        p.dir = dir;
        while (t <= f) begin
            p.t = t;
            exp_q.push_back(p);
            t += (t == t0) ? RD : RP;
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (resetn && (rotate_left || rotate_right)) begin
            check_eq("pulse_exclusive", int'(rotate_left & rotate_right), 0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", cyc, -1);
            end else begin
                mon_p = exp_q.pop_front();
                check_eq("pulse_time", cyc, mon_p.t);
                check_eq("pulse_dir", int'(rotate_right), int'(mon_p.dir));
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check_eq("rst_rotate_left", rotate_left, 0);
        check_eq("rst_rotate_right", rotate_right, 0);
        check_eq("rst_pressed_left", pressed_left, 0);
        check_eq("rst_pressed_right", pressed_right, 0);
        resetn = 1'b1;
        wait_to(cyc + 5);

        // Tap: left low for 10 cycles
        n = cyc;
        key_left_n = 1'b0;
        push_hold(1'b0, n + 7, n + 16);
        wait_to(n + 5);
        check_eq("tap_pressed_early", pressed_left, 0);
        wait_to(n + 6);
        check_eq("tap_pressed_rise", pressed_left, 1);
        wait_to(n + 10);
        key_left_n = 1'b1;
        wait_to(n + 15);
        check_eq("tap_pressed_hold", pressed_left, 1);
        wait_to(n + 16);
        check_eq("tap_pressed_fall", pressed_left, 0);
        check_eq("tap_pressed_right", pressed_right, 0);
        wait_to(n + 40);
        check_eq("tap_q_empty", exp_q.size(), 0);

        // Hold: right held 60 cycles
        n = cyc;
        key_right_n = 1'b0;
        push_hold(1'b1, n + 7, n + 66);
        wait_to(n + 60);
        key_right_n = 1'b1;
        wait_to(n + 65);
        check_eq("hold_pressed_before_fall", pressed_right, 1);
        wait_to(n + 66);
        check_eq("hold_pressed_fall", pressed_right, 0);
        wait_to(n + 90);
        check_eq("hold_q_empty", exp_q.size(), 0);

        // Bounce: left toggles every 2 cycles for 20 cycles
        n = cyc;
        seen = 1'b0;
        for (int j = 0; j < 30; j++) begin
            key_left_n = (j < 20) ? (((j / 2) % 2) == 1) : 1'b1;
            seen |= pressed_left;
            @(negedge clock);
        end
        check_eq("bounce_pressed_seen", int'(seen), 0);
        check_eq("bounce_q_empty", exp_q.size(), 0);
        wait_to(cyc + 10);

        // Simultaneous press, then release right
        n = cyc;
        key_left_n  = 1'b0;
        key_right_n = 1'b0;
        wait_to(n + 6);
        check_eq("simul_pressed_left", pressed_left, 1);
        check_eq("simul_pressed_right", pressed_right, 1);
        wait_to(n + 30);
        key_right_n = 1'b1;
        push_hold(1'b0, n + 37, n + 76);
        wait_to(n + 36);
        check_eq("simul_right_fall", pressed_right, 0);
        wait_to(n + 70);
        key_left_n = 1'b1;
        wait_to(n + 100);
        check_eq("simul_q_empty", exp_q.size(), 0);

        // Takeover: left repeating, right pressed, then left released
        n = cyc;
        key_left_n = 1'b0;
        push_hold(1'b0, n + 7, n + 36);
        push_hold(1'b1, n + 57, n + 76);
        wait_to(n + 30);
        key_right_n = 1'b0;
        wait_to(n + 36);
        check_eq("takeover_right_rise", pressed_right, 1);
        wait_to(n + 50);
        key_left_n = 1'b1;
        wait_to(n + 56);
        check_eq("takeover_left_fall", pressed_left, 0);
        wait_to(n + 70);
        key_right_n = 1'b1;
        wait_to(n + 100);
        check_eq("takeover_q_empty", exp_q.size(), 0);

        // Reset mid-repeat: assert while a left repeat pulse is high
        n = cyc;
        key_left_n = 1'b0;
        push_hold(1'b0, n + 7, n + 35);
        wait_to(n + 35);
        #1 resetn = 1'b0;
        #1;
        check_eq("arst_rotate_left", rotate_left, 0);
        check_eq("arst_rotate_right", rotate_right, 0);
        check_eq("arst_pressed_left", pressed_left, 0);
        check_eq("arst_pressed_right", pressed_right, 0);
        wait_to(n + 40);
        resetn = 1'b1;
        m = cyc;
        push_hold(1'b0, m + 7, m + 26);
        wait_to(m + 5);
        check_eq("arst_pressed_early", pressed_left, 0);
        wait_to(m + 6);
        check_eq("arst_pressed_rise", pressed_left, 1);
        wait_to(m + 20);
        key_left_n = 1'b1;
        wait_to(m + 26);
        check_eq("arst_pressed_fall", pressed_left, 0);
        wait_to(m + 50);
        check_eq("arst_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rotate_key_conditioner.md
# rotate_key_conditioner

Front-end conditioner for the rotation push-buttons. It synchronizes and debounces the two raw active-low keys, then emits single-cycle `rotate_left`/`rotate_right` command pulses with hold-to-auto-repeat. Its outputs are the command stream consumed by `input_control`, which integrates the pulses into `angle_X`/`angle_Y`. The raw KEY pins connect here instead of being inverted straight into `input_control`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz). Must be ≥2.
- `REPEAT_DELAY`, default 25_000_000: cycles from the first pulse to the first repeat pulse. Must be ≥2.
- `REPEAT_PERIOD`, default 5_000_000: cycles between later repeat pulses. Must be ≥2.

Ports:
- `clock` in 1: system clock (CLOCK_50).
- `resetn` in 1: asynchronous, active-low reset.
- `key_left_n` in 1: raw KEY[1]. Asynchronous, 0 = pressed.
- `key_right_n` in 1: raw KEY[0]. Asynchronous, 0 = pressed.
- `rotate_left` out 1: one-cycle command pulse, connects to `input_control.rotate_left`.
- `rotate_right` out 1: one-cycle command pulse, connects to `input_control.rotate_right`.
- `pressed_left` out 1: debounced level, 1 = held.
- `pressed_right` out 1: debounced level, 1 = held.

## Operation
- **Reset (async, `resetn`=0):**
  - Synchronizer flops are set to 1 (released).
  - Debounce counters are 0; `pressed_*` are 0.
  - FSM is IDLE; timer is 0; `rotate_*` are 0.
- **Synchronizer:** two flops per key. Logic past this point sees only the synchronized signal `s_*`.
- **Debounce (one per key):**
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - When `s_*` equals the current debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, the debounced level flips on that edge and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `pressed_*`.
- **Repeat FSM:** shared by both keys. Holds a latched direction `dir` and a timer of width `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD))`.
  - **IDLE:** if exactly one of `pressed_left`/`pressed_right` is 1:
    - latch `dir`;
    - assert that key's `rotate_*` for the next cycle;
    - clear the timer;
    - go to DELAY.
    - If both or neither are pressed, stay in IDLE with no pulse.
  - **DELAY:** the timer increments.
    - When the timer reaches `REPEAT_DELAY-1`: pulse `rotate_<dir>`, clear the timer, go to REPEAT.
  - **REPEAT:** the timer increments.
    - When the timer reaches `REPEAT_PERIOD-1`: pulse `rotate_<dir>`, clear the timer, stay in REPEAT.
  - **Abort (DELAY or REPEAT):** if the `dir` key is no longer pressed, or the opposite key becomes pressed:
    - go to IDLE that cycle with no pulse and clear the timer;
    - abort takes priority over a coincident timer expiry.
    - If the opposite key is now held alone, IDLE issues a new first pulse for it on the following cycle.
- **Pulse rules:**
  - `rotate_left` and `rotate_right` are registered outputs.
  - They are never high together.
  - Each pulse is exactly one cycle wide.

## Timing
- **Press latency:** raw key first sampled low at edge k gives:
  - `pressed_*` = 1 after edge k+1+`DEBOUNCE_CYCLES`;
  - first `rotate_*` pulse high after edge k+2+`DEBOUNCE_CYCLES`, for one cycle.
- **Release latency:** `pressed_*` falls `DEBOUNCE_CYCLES`+1 edges after the raw release is sampled. No pulse is issued after that point.
- **Pulse spacing while held:**
  - first to second pulse: exactly `REPEAT_DELAY` cycles;
  - every later pulse: `REPEAT_PERIOD` cycles apart.
- **Short tap:** a press held for less than `REPEAT_DELAY` debounced cycles produces exactly one pulse.
- **Asynchronous reset mid-repeat:** pulses stop immediately. After `resetn` rises, a key still held produces a new first pulse at the normal press latency, because the synchronizers reset to released.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.

- **Tap:** left low for 10 cycles, then high.
  - `pressed_left` high for about 10 cycles.
  - Exactly one `rotate_left` pulse, at sample edge + 6.
  - No `rotate_right` pulse.
- **Hold:** right held for 60 cycles.
  - `rotate_right` pulses at t0, t0+20, t0+28, t0+36, t0+44, ... until release.
  - No pulse after `pressed_right` falls.
- **Bounce:** left toggles every 2 cycles for 20 cycles, then stays high.
  - `pressed_left` stays 0.
  - Zero `rotate_*` pulses.
- **Simultaneous press:**
  - Both keys held together: both `pressed_*` = 1 and no pulses.
  - Then release right: one `rotate_left` first pulse, followed by the normal repeat cadence.
- **Takeover:** hold left past its first repeat, then press right.
  - Left repeats stop.
  - No `rotate_right` pulse while both keys are held.
  - Release left: a `rotate_right` first pulse one cycle after `pressed_left` falls.
- **Reset mid-repeat:** assert `resetn`=0 during REPEAT with left held.
  - All outputs are 0 asynchronously.
  - After `resetn` is released with left still held, the first pulse arrives after `DEBOUNCE_CYCLES`+3 edges.
